rpn_sequencer: RTL and testbench
================================

Name: rpn_sequencer

Overview:
- Command sequencer and ALU that sits directly upstream of the calculator's 64-entry operand stack.
- Accepts decoded keypad commands (digit, enter, arithmetic, drop, clear) and reads the stack's top, next and count.
- Drives the stack's push/pop/write/reset controls and write value to perform RPN evaluation.
- Includes a multi-cycle signed divider and a sticky error report for the display.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, width of stack element count (stack depth 2^CNT_W)

Ports:
clock  in  1  system clock (50 MHz); all logic on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer idle, command accepted when cmd_valid && cmd_ready
cmd_op  in  4  opcode (calc_pkg)
cmd_digit  in  4  decimal digit 0-9, used by OP_DIGIT only
stk_top  in  WIDTH  stack top element
stk_next  in  WIDTH  second element (0 if only one)
stk_count  in  CNT_W  element count; 0 means full (2^CNT_W entries)
stk_error  in  1  stack pointer overflow flag
stk_push  out  1  one-cycle push strobe (stack pushes a zero)
stk_pop  out  1  one-cycle pop strobe
stk_write  out  1  one-cycle overwrite-top strobe
stk_value  out  WIDTH  value written with stk_write
stk_reset  out  1  active-high stack clear
busy  out  1  = !cmd_ready
err_code  out  2  sticky: 0 none, 1 underflow, 2 overflow, 3 divide-by-zero

Behaviour:
- Reset (reset==0 at edge): state IDLE; cmd_ready=1; stk_push/pop/write=0; stk_value=0; err_code=0; operand and divider registers 0. stk_reset = !reset | clear_pulse, so the stack clears while reset is low. Reset mid-operation aborts; no further strobes are issued.
- States: IDLE, DIV_RUN, POP, WRITE. All strobes are registered, one-cycle pulses. cmd_ready=1 only in IDLE.
- On accept, latch a=stk_next, b=stk_top, op. Operands are never re-read after acceptance.
- OP_DIGIT: next cycle stk_write=1, stk_value = b*10 + digit (mod 2^WIDTH); return to IDLE. Latency 1.
- OP_ENTER:
  - If stk_count==0 or stk_error: err_code=2, no strobe.
  - Else next cycle stk_push=1.
- OP_NEG: next cycle write 0-b. INT_MIN stays INT_MIN.
- OP_DROP:
  - If stk_count==1: write 0 (stack never empties).
  - Else pop.
- OP_CLEAR: next cycle stk_reset=1; err_code cleared to 0.
- OP_ADD/SUB/MUL:
  - If stk_count==1: err_code=1, stay IDLE, no strobes.
  - Else POP cycle (stk_pop=1), then WRITE cycle (stk_write=1, stk_value = a op b, low WIDTH bits, two's-complement wrap), then IDLE. Ready-to-ready 3 cycles.
  - SUB computes a-b (next minus top).
- OP_DIV/OP_MOD:
  - Underflow check as above. If b==0: err_code=3, no strobes, stack unchanged.
  - Else DIV_RUN for exactly WIDTH cycles (restoring, unsigned magnitudes), then POP, WRITE.
  - Quotient truncates toward zero; its sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - INT_MIN / -1 gives INT_MIN; INT_MIN mod -1 gives 0.
- err_code priority if several conditions apply: underflow > div0. A new error overwrites the old one; only CLEAR or reset zeroes it. Errors do not block later commands.
- Undefined opcodes are accepted and treated as no-ops (1-cycle, no strobes).
- Never asserts stk_push, stk_pop and stk_write in the same cycle.
- Never asserts stk_write in the same cycle as stk_pop.

Decomposition:
- calc_pkg: opcode constants OP_DIGIT=0, ENTER=1, ADD=2, SUB=3, MUL=4, DIV=5, MOD=6, NEG=7, DROP=8, CLEAR=9; err_code constants; state enum; WIDTH default.
- Sub-module seq_divider:
  - Inputs: start, dividend, divisor (unsigned WIDTH).
  - Outputs: quotient, remainder, done pulse after WIDTH cycles.
  - Synchronous active-low reset.
  - Sign fix-up stays in rpn_sequencer.

Test Plan:
- Digit entry: DIGIT 1, DIGIT 2, DIGIT 3 on top=0 -> three writes with values 1, 12, 123; cmd_ready low exactly 1 cycle after each.
- Add: top=7 next=5 count=2, ADD -> stk_pop at T+1, stk_write value 12 at T+2, cmd_ready high at T+3; SUB in the same setup -> value -2 (0xFFFFFFFE).
- Signed divide: next=-7 top=2, DIV -> 32 busy cycles, then pop, then write -3; MOD -> -1; next=0x80000000 top=-1 DIV -> 0x80000000.
- Errors:
  - count=1, ADD -> err_code=1, no strobes.
  - top=0 count=2, DIV -> err_code=3, stack untouched.
  - count=0, ENTER -> err_code=2, no push.
  - Then CLEAR -> stk_reset pulse, err_code=0.
- Reset mid-divide: drop reset at DIV_RUN cycle 10 -> next cycle IDLE, no pop/write ever issued, stk_reset high while reset low.
- Back-to-back: cmd_valid held high with ENTER, DIGIT 4, ADD -> each accepted only when cmd_ready=1; the only strobe sequence is push, write, pop, write.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Brief   : Opcodes, error codes, sequencer state encoding, default widths.
// Revision: 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;

    localparam logic [3:0] OP_DIGIT = 4'd0;
    localparam logic [3:0] OP_ENTER = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_MOD   = 4'd6;
    localparam logic [3:0] OP_NEG   = 4'd7;
    localparam logic [3:0] OP_DROP  = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_DIV_ZERO  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_POP     = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : Restoring unsigned divider; first step taken on start, done pulse
//           registered so results are valid exactly WIDTH cycles after start.
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] src_rem, src_quo;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, done_q, done_d;

    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        dvs_d   = start ? divisor : dvs_q;
        trial   = {src_rem, src_quo[WIDTH-1]};
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        if (start || run_q) begin
            quo_d = {src_quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvs_d}) begin
                rem_d    = trial[WIDTH-1:0] - dvs_d;
                quo_d[0] = 1'b1;
            end else begin
                rem_d = trial[WIDTH-1:0];
            end
        end
        if (start) begin
            cnt_d = CW'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: rtl/rpn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rpn_sequencer
// Brief   : RPN command sequencer and ALU driving a 64-entry operand stack.
// Revision: 1.0 - initial release
// ============================================================================
module rpn_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_digit,
    input  logic [WIDTH-1:0] stk_top,
    input  logic [WIDTH-1:0] stk_next,
    input  logic [CNT_W-1:0] stk_count,
    input  logic             stk_error,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_write,
    output logic [WIDTH-1:0] stk_value,
    output logic             stk_reset,
    output logic             busy,
    output logic [1:0]       err_code
);

    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, value_q, value_d;
    logic             push_q, push_d, pop_q, pop_d, write_q, write_d, clear_q, clear_d;
    logic [1:0]       err_q, err_d;
    logic             div_start, div_done, one_elem;
    logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem;

    // Divider runs on magnitudes; signs are restored from the latched operands.
    assign div_dividend = stk_next[WIDTH-1] ? '0 - stk_next : stk_next;
    assign div_divisor  = stk_top[WIDTH-1]  ? '0 - stk_top  : stk_top;
    assign one_elem     = (stk_count == CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        value_d   = value_q;
        err_d     = err_q;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        write_d   = 1'b0;
        clear_d   = 1'b0;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = stk_next;
                    b_d  = stk_top;
                    case (cmd_op)
                        OP_DIGIT: begin
                            write_d = 1'b1;
                            value_d = stk_top * TEN + {{(WIDTH-4){1'b0}}, cmd_digit};
                            state_d = S_WRITE;
                        end
                        OP_ENTER: begin
                            if (stk_count == '0 || stk_error) begin
                                err_d = ERR_OVERFLOW;
                            end else begin
                                push_d  = 1'b1;
                                state_d = S_WRITE;
                            end
                        end
                        OP_NEG: begin
                            write_d = 1'b1;
                            value_d = '0 - stk_top;
                            state_d = S_WRITE;
                        end
                        OP_DROP: begin
                            if (one_elem) begin
                                write_d = 1'b1;
                                value_d = '0;
                                state_d = S_WRITE;
                            end else begin
                                pop_d   = 1'b1;
                                state_d = S_POP;
                            end
                        end
                        OP_CLEAR: begin
                            clear_d = 1'b1;
                            err_d   = ERR_NONE;
                            state_d = S_WRITE;
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            if (one_elem) begin
                                err_d = ERR_UNDERFLOW;
                            end else begin
                                pop_d   = 1'b1;
                                state_d = S_POP;
                            end
                        end
                        OP_DIV, OP_MOD: begin
                            if (one_elem) begin
                                err_d = ERR_UNDERFLOW;
                            end else if (stk_top == '0) begin
                                err_d = ERR_DIV_ZERO;
                            end else begin
                                div_start = 1'b1;
                                state_d   = S_DIV_RUN;
                            end
                        end
                        // Undefined opcodes still spend one busy cycle, silently.
                        default: state_d = S_WRITE;
                    endcase
                end
            end
            S_DIV_RUN: begin
                if (div_done) begin
                    pop_d   = 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (op_q == OP_DROP) begin
                    state_d = S_IDLE;
                end else begin
                    write_d = 1'b1;
                    state_d = S_WRITE;
                    case (op_q)
                        OP_ADD:  value_d = a_q + b_q;
                        OP_SUB:  value_d = a_q - b_q;
                        OP_MUL:  value_d = a_q * b_q;
                        OP_DIV:  value_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? '0 - div_quo : div_quo;
                        default: value_d = a_q[WIDTH-1] ? '0 - div_rem : div_rem;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            value_q <= '0;
            err_q   <= ERR_NONE;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            write_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            value_q <= value_d;
            err_q   <= err_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            write_q <= write_d;
            clear_q <= clear_d;
        end
    end

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_write = write_q;
    assign stk_value = value_q;
    assign stk_reset = !reset | clear_q;
    assign err_code  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rpn_sequencer
// Brief   : Directed and randomized bench against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rpn_sequencer;
    import calc_pkg::*;

    localparam logic [3:0] C_PUSH = 4'b1000;
    localparam logic [3:0] C_POP  = 4'b0100;
    localparam logic [3:0] C_WR   = 4'b0010;
    localparam logic [3:0] C_CLR  = 4'b0001;
    localparam logic [3:0] C_NONE = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [3:0]  cmd_digit = '0;
    logic [31:0] stk_top = '0;
    logic [31:0] stk_next = '0;
    logic [5:0]  stk_count = 6'd1;
    logic        stk_error = 1'b0;
    logic        stk_push, stk_pop, stk_write, stk_reset, busy;
    logic [31:0] stk_value;
    logic [1:0]  err_code;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  err_m = ERR_NONE;

    always #10 clk = ~clk;

    rpn_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_digit (cmd_digit),
        .stk_top   (stk_top),
        .stk_next  (stk_next),
        .stk_count (stk_count),
        .stk_error (stk_error),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_write (stk_write),
        .stk_value (stk_value),
        .stk_reset (stk_reset),
        .busy      (busy),
        .err_code  (err_code)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected busy cycles, strobe trace, last written value, error code.
    function automatic void model(input logic [3:0] op, input logic [3:0] dg,
                                  input logic [31:0] top, input logic [31:0] nxt,
                                  input logic [5:0] cnt, input logic serr, input logic [1:0] err_in,
                                  output int cyc, output logic [255:0] seq,
                                  output logic [31:0] val, output logic [1:0] err_out);
        longint sa, sb, q, r;
        cyc = 0; seq = '0; val = '0; err_out = err_in;
        sa = longint'($signed(nxt));
        sb = longint'($signed(top));
        case (op)
            OP_DIGIT: begin cyc = 1; seq = 256'(C_WR); val = top * 32'd10 + 32'(dg); end
            OP_ENTER: begin
                if (cnt == 0 || serr) err_out = ERR_OVERFLOW;
                else begin cyc = 1; seq = 256'(C_PUSH); end
            end
            OP_NEG:   begin cyc = 1; seq = 256'(C_WR); val = 32'd0 - top; end
            OP_DROP:  begin
                cyc = 1;
                if (cnt == 1) begin seq = 256'(C_WR); val = '0; end
                else seq = 256'(C_POP);
            end
            OP_CLEAR: begin cyc = 1; seq = 256'(C_CLR); err_out = ERR_NONE; end
            OP_ADD, OP_SUB, OP_MUL: begin
                if (cnt == 1) err_out = ERR_UNDERFLOW;
                else begin
                    cyc = 2; seq = {248'd0, C_POP, C_WR};
                    val = (op == OP_ADD) ? nxt + top : (op == OP_SUB) ? nxt - top : nxt * top;
                end
            end
            OP_DIV, OP_MOD: begin
                if (cnt == 1) err_out = ERR_UNDERFLOW;
                else if (top == 0) err_out = ERR_DIV_ZERO;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    cyc = 32 + 2;
                    seq = {248'd0, C_POP, C_WR};
                    val = (op == OP_DIV) ? 32'(q) : 32'(r);
                end
            end
            default: begin cyc = 1; seq = 256'(C_NONE); end
        endcase
    endfunction

    task automatic do_cmd(input logic [3:0] op, input logic [3:0] dg, input logic [31:0] top,
                          input logic [31:0] nxt, input logic [5:0] cnt, input logic serr,
                          input string tag);
        int          ecyc, ocyc;
        logic [255:0] eseq, oseq;
        logic [31:0] eval, oval;
        logic [1:0]  eerr;
        logic [3:0]  code;
        model(op, dg, top, nxt, cnt, serr, err_m, ecyc, eseq, eval, eerr);
        err_m = eerr;
        @(negedge clk);
        check({tag, " ready_before"}, 256'(cmd_ready), 256'(1));
        cmd_op = op; cmd_digit = dg; stk_top = top; stk_next = nxt;
        stk_count = cnt; stk_error = serr; cmd_valid = 1'b1;
        @(negedge clk);
        // Operands change after acceptance; the result must not depend on them.
        cmd_valid = 1'b0; stk_top = $urandom; stk_next = $urandom;
        ocyc = 0; oseq = '0; oval = '0;
        while (!cmd_ready && ocyc < 100) begin
            code = {stk_push, stk_pop, stk_write, stk_reset};
            check({tag, " strobe_onehot"}, 256'($countones(code) <= 1), 256'(1));
            check({tag, " busy"}, 256'(busy), 256'(1));
            oseq = {oseq[251:0], code};
            if (stk_write) oval = stk_value;
            ocyc++;
            @(negedge clk);
        end
        code = {stk_push, stk_pop, stk_write, stk_reset};
        check({tag, " cycles"}, 256'(ocyc), 256'(ecyc));
        check({tag, " strobes"}, oseq, eseq);
        check({tag, " value"}, 256'(oval), 256'(eval));
        check({tag, " err_code"}, 256'(err_code), 256'(eerr));
        check({tag, " idle_quiet"}, 256'(code), 256'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   op, code;
        logic [31:0]  t, n;
        logic [5:0]   c;
        logic [255:0] bseq;
        logic [31:0]  bval;
        logic [3:0]   bops [3];
        int           nacc;
        logic         will, bad;

        repeat (3) @(negedge clk);
        check("reset ready", 256'(cmd_ready), 256'(1));
        check("reset strobes", 256'({stk_push, stk_pop, stk_write}), 256'(0));
        check("reset value", 256'(stk_value), 256'(0));
        check("reset err", 256'(err_code), 256'(0));
        check("reset stk_reset", 256'(stk_reset), 256'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset stk_reset", 256'(stk_reset), 256'(0));

        do_cmd(OP_DIGIT, 4'd1, 32'd0,  32'd0, 6'd1, 1'b0, "digit1");
        do_cmd(OP_DIGIT, 4'd2, 32'd1,  32'd0, 6'd1, 1'b0, "digit2");
        do_cmd(OP_DIGIT, 4'd3, 32'd12, 32'd0, 6'd1, 1'b0, "digit3");
        do_cmd(OP_ADD, 4'd0, 32'd7, 32'd5, 6'd2, 1'b0, "add");
        do_cmd(OP_SUB, 4'd0, 32'd7, 32'd5, 6'd2, 1'b0, "sub");
        do_cmd(OP_MUL, 4'd0, 32'hFFFF_FFFD, 32'd9, 6'd5, 1'b0, "mul");
        do_cmd(OP_DIV, 4'd0, 32'd2, 32'hFFFF_FFF9, 6'd2, 1'b0, "div_neg");
        do_cmd(OP_MOD, 4'd0, 32'd2, 32'hFFFF_FFF9, 6'd2, 1'b0, "mod_neg");
        do_cmd(OP_DIV, 4'd0, 32'hFFFF_FFFF, 32'h8000_0000, 6'd2, 1'b0, "div_intmin");
        do_cmd(OP_MOD, 4'd0, 32'hFFFF_FFFF, 32'h8000_0000, 6'd2, 1'b0, "mod_intmin");
        do_cmd(OP_ADD, 4'd0, 32'd3, 32'd0, 6'd1, 1'b0, "add_underflow");
        do_cmd(OP_DIV, 4'd0, 32'd0, 32'd9, 6'd2, 1'b0, "div_zero");
        do_cmd(OP_DIV, 4'd0, 32'd0, 32'd9, 6'd1, 1'b0, "div_under_prio");
        do_cmd(OP_ENTER, 4'd0, 32'd4, 32'd1, 6'd0, 1'b0, "enter_full");
        do_cmd(OP_CLEAR, 4'd0, 32'd4, 32'd1, 6'd3, 1'b0, "clear");
        do_cmd(OP_ENTER, 4'd0, 32'd4, 32'd1, 6'd3, 1'b1, "enter_stkerr");
        do_cmd(OP_ENTER, 4'd0, 32'd4, 32'd1, 6'd3, 1'b0, "enter_ok");
        do_cmd(OP_NEG, 4'd0, 32'h8000_0000, 32'd1, 6'd3, 1'b0, "neg_intmin");
        do_cmd(OP_DROP, 4'd0, 32'd8, 32'd0, 6'd1, 1'b0, "drop_last");
        do_cmd(OP_DROP, 4'd0, 32'd8, 32'd2, 6'd4, 1'b0, "drop_pop");
        do_cmd(4'd12, 4'd0, 32'd8, 32'd2, 6'd4, 1'b0, "undefined");

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 13));
            if (op > 4'd9) op = 4'($urandom_range(10, 15));
            case ($urandom_range(0, 5))
                0: t = '0;
                1: t = 32'hFFFF_FFFF;
                2: t = 32'($urandom_range(1, 20));
                default: t = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: n = 32'h8000_0000;
                1: n = 32'($urandom_range(0, 200));
                default: n = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: c = 6'd0;
                1: c = 6'd1;
                default: c = 6'($urandom_range(2, 63));
            endcase
            do_cmd(op, 4'($urandom_range(0, 9)), t, n, c, ($urandom_range(0, 7) == 0), "random");
        end

        // Back-to-back: valid held high, command advanced only after acceptance.
        bops[0] = OP_ENTER; bops[1] = OP_DIGIT; bops[2] = OP_ADD;
        @(negedge clk);
        stk_top = 32'd5; stk_next = 32'd3; stk_count = 6'd2; stk_error = 1'b0;
        cmd_digit = 4'd4; cmd_op = bops[0]; cmd_valid = 1'b1;
        nacc = 0; bseq = '0; bval = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            will = cmd_ready && cmd_valid;
            @(posedge clk);
            #1;
            if (will) begin
                nacc++;
                if (nacc < 3) cmd_op = bops[nacc];
                else cmd_valid = 1'b0;
            end
            @(negedge clk);
            code = {stk_push, stk_pop, stk_write, stk_reset};
            if (code != 4'd0) bseq = {bseq[251:0], code};
            if (stk_write) bval = stk_value;
        end
        check("b2b accepts", 256'(nacc), 256'(3));
        check("b2b strobes", bseq, {240'd0, C_PUSH, C_WR, C_POP, C_WR});
        check("b2b value", 256'(bval), 256'(32'd8));

        // Reset during the divider run.
        @(negedge clk);
        cmd_op = OP_DIV; stk_top = 32'd2; stk_next = 32'd9; stk_count = 6'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_div busy", 256'(busy), 256'(1));
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_div stk_reset", 256'(stk_reset), 256'(1));
        @(negedge clk);
        check("mid_div idle", 256'(cmd_ready), 256'(1));
        check("mid_div stk_reset_held", 256'(stk_reset), 256'(1));
        check("mid_div err", 256'(err_code), 256'(0));
        rst_n = 1'b1;
        err_m = ERR_NONE;
        bad = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (stk_pop || stk_write || stk_push || !cmd_ready) bad = 1'b1;
        end
        check("mid_div no_strobes", 256'(bad), 256'(0));
        do_cmd(OP_ADD, 4'd0, 32'd1, 32'd2, 6'd2, 1'b0, "post_reset_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
